// File: rtl/window_seq_ctrl.sv
// Window sequencer: drops warm-up/row-straddling windows and tags valid ones with sof/eol/eof.
// Optional frame statistics counter built only when WINDOW_SEQ_CTRL_STATS_EN is defined.
module window_seq_ctrl #(
  parameter int IMG_WIDTH    = 854,
  parameter int IMG_HEIGHT   = 480,
  parameter int BUFFER_WIDTH = 8,
  parameter int BLOCK_WIDTH  = 3,
  parameter int BLOCK_HEIGHT = 3,
  parameter int KERNEL_WIDTH = BLOCK_WIDTH*BLOCK_HEIGHT*BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    frame_rst,
  input  logic                    lb_valid,
  input  logic [KERNEL_WIDTH-1:0] lb_kernel,
  output logic                    lb_ready,
  output logic                    out_valid,
  output logic [KERNEL_WIDTH-1:0] out_kernel,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [15:0]             frame_count
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0] COL_FWD  = CW'(BLOCK_WIDTH-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT-1);
  localparam logic [RW-1:0] ROW_FWD  = RW'(BLOCK_HEIGHT-1);
  localparam logic [RW-1:0] ROW_PRE  = RW'(BLOCK_HEIGHT-2);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          beat, fwd;
  logic          at_col_last, at_row_last;
  logic          m_sof, m_eol, m_eof;

  assign at_col_last = (col == COL_LAST);
  assign at_row_last = (row == ROW_LAST);

  // A single output register: accept only when it is empty or draining this cycle.
  assign lb_ready = (state != IDLE) && !frame_rst && (!out_valid || out_ready);
  assign beat     = lb_valid && lb_ready;
  assign fwd      = beat && (state == STREAM) && (row >= ROW_FWD) && (col >= COL_FWD);

  assign m_sof = (row == ROW_FWD) && (col == COL_FWD);
  assign m_eol = at_col_last;
  assign m_eof = at_col_last && at_row_last;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    if (frame_rst) begin
      state_nxt = enable ? FILL : IDLE;
    end else begin
      case (state)
        IDLE:   if (enable) state_nxt = FILL;
        FILL:   if (beat && at_col_last && (row == ROW_PRE)) state_nxt = STREAM;
        STREAM: if (fwd && m_eof) state_nxt = enable ? FILL : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Raster position of the newest pixel of the next beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (frame_rst) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      if (at_col_last) begin
        col <= '0;
        row <= at_row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_kernel <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
    end else if (frame_rst || (out_valid && out_ready && !fwd)) begin
      out_valid  <= 1'b0;
      out_kernel <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
    end else if (fwd) begin
      out_valid  <= 1'b1;
      out_kernel <= lb_kernel;
      out_sof    <= m_sof;
      out_eol    <= m_eol;
      out_eof    <= m_eof;
    end
  end

`ifdef WINDOW_SEQ_CTRL_STATS_EN
  logic [15:0] fcnt;

  // Counted when the eof window enters the output register; frame_rst never reaches here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             fcnt <= '0;
    else if (fwd && m_eof) fcnt <= fcnt + 16'd1;
  end

  assign frame_count = fcnt;
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Directed bench for window_seq_ctrl on an 8x6 image with a 3x3 window.
module tb_window_seq_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int KW = 72;
`ifdef WINDOW_SEQ_CTRL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0, frame_rst = 1'b0, lb_valid = 1'b0, out_ready = 1'b1;
  logic [KW-1:0] lb_kernel = '0;
  logic          lb_ready, out_valid, out_sof, out_eol, out_eof, busy;
  logic [KW-1:0] out_kernel;
  logic [15:0]   frame_count;

  window_seq_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BUFFER_WIDTH(8),
                    .BLOCK_WIDTH(3), .BLOCK_HEIGHT(3), .KERNEL_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_rst(frame_rst),
    .lb_valid(lb_valid), .lb_kernel(lb_kernel), .lb_ready(lb_ready),
    .out_valid(out_valid), .out_kernel(out_kernel), .out_sof(out_sof),
    .out_eol(out_eol), .out_eof(out_eof), .out_ready(out_ready),
    .busy(busy), .frame_count(frame_count));

  always #5 clk = ~clk;

  typedef struct { logic [KW-1:0] k; logic [2:0] mk; } win_t;
  win_t q[$];

  int n_chk = 0, n_pass = 0, seq = 0;
  logic drv_valid = 1'b0, drv_frst = 1'b0, drv_en = 1'b1;
  int   ordy_mode = 0;  // 0: always ready, 1: toggle, 2: never ready
  logic prev_stall = 1'b0, prev_frst = 1'b0;
  logic [KW-1:0] prev_k;
  logic [2:0]    prev_mk;
  int   cyc_n = 0;

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, sample 1ns later, DUT captures on the following posedge.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    enable    = drv_en;
    frame_rst = drv_frst;
    lb_valid  = drv_valid;
    lb_kernel = KW'(seq);
    out_ready = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 1) ? cyc_n[0] : 1'b0;
    #1;
    if (prev_stall && !prev_frst) begin
      chk("stall_vld", {71'd0, out_valid}, 72'd1);
      chk("stall_kern", out_kernel, prev_k);
      chk("stall_mk", {69'd0, out_sof, out_eol, out_eof}, {69'd0, prev_mk});
    end
    prev_stall = out_valid && !out_ready;
    prev_frst  = frame_rst;
    prev_k     = out_kernel;
    prev_mk    = {out_sof, out_eol, out_eof};
    if (out_valid && out_ready) q.push_back('{k: out_kernel, mk: {out_sof, out_eol, out_eof}});
    if (lb_valid && lb_ready) seq++;
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (seq < target && guard < 400) begin cyc(); guard++; end
    chk("beat_budget", KW'(seq), KW'(target));
  endtask

  task automatic drain();
    drv_valid = 1'b0;
    ordy_mode = 0;
    repeat (4) cyc();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drv_valid = 1'b0; drv_frst = 1'b0; drv_en = 1'b1; ordy_mode = 0;
    lb_valid = 1'b0; frame_rst = 1'b0;
    #1;
    chk("rst_vld", {71'd0, out_valid}, 72'd0);
    chk("rst_kern", out_kernel, 72'd0);
    chk("rst_mk", {69'd0, out_sof, out_eol, out_eof}, 72'd0);
    chk("rst_busy", {71'd0, busy}, 72'd0);
    chk("rst_fcnt", {56'd0, frame_count}, 72'd0);
    chk("rst_rdy", {71'd0, lb_ready}, 72'd0);
    @(negedge clk);
    rst = 1'b1;
    seq = 0; q.delete(); prev_stall = 1'b0; prev_frst = 1'b0;
  endtask

  // Window k of a frame sits at row 2+k/6, col 2+k%6; kernel carries the beat number.
  task automatic verify(input int base, input int q0);
    for (int k = 0; k < 24; k++) begin
      if (q0 + k < q.size()) begin
        int r, c;
        r = 2 + k / 6;
        c = 2 + k % 6;
        chk("win_kern", q[q0+k].k, KW'(base + r*W + c));
        chk("win_mk", {69'd0, q[q0+k].mk},
            {69'd0, (k == 0), (k % 6 == 5), (k == 23)});
      end
    end
  endtask

  initial begin
    // Frame with continuous input and ready
    do_reset();
    drv_valid = 1'b1;
    run_until(48);
    drain();
    chk("f1_count", KW'(q.size()), KW'(24));
    verify(0, 0);
    chk("f1_fcnt", {56'd0, frame_count}, KW'(STATS));
    chk("f1_busy", {71'd0, busy}, 72'd1);

    // Same frame with toggling downstream ready
    do_reset();
    drv_valid = 1'b1; ordy_mode = 1;
    run_until(48);
    drain();
    chk("f2_count", KW'(q.size()), KW'(24));
    verify(0, 0);

    // Two back-to-back frames
    do_reset();
    drv_valid = 1'b1;
    run_until(96);
    drain();
    chk("f3_count", KW'(q.size()), KW'(48));
    verify(0, 0);
    verify(48, 24);
    chk("f3_fcnt", {56'd0, frame_count}, KW'(2*STATS));

    // frame_rst after beat 30 while a window is stalled in the output register
    do_reset();
    drv_valid = 1'b1;
    run_until(30);
    ordy_mode = 2; drv_frst = 1'b1;
    cyc();
    chk("frst_rdy", {71'd0, lb_ready}, 72'd0);
    drv_frst = 1'b0; ordy_mode = 0; drv_valid = 1'b0;
    cyc();
    chk("frst_vld", {71'd0, out_valid}, 72'd0);
    chk("frst_pre", KW'(q.size()), KW'(9));
    q.delete();
    drv_valid = 1'b1;
    run_until(78);
    drain();
    chk("frst_count", KW'(q.size()), KW'(24));
    verify(30, 0);
    chk("frst_fcnt", {56'd0, frame_count}, KW'(STATS));

    // enable dropped during beat 20: frame still completes, then idles
    do_reset();
    drv_valid = 1'b1;
    run_until(20);
    drv_en = 1'b0;
    run_until(48);
    drv_valid = 1'b1;
    repeat (5) cyc();
    chk("en_seq", KW'(seq), KW'(48));
    chk("en_busy", {71'd0, busy}, 72'd0);
    chk("en_rdy", {71'd0, lb_ready}, 72'd0);
    drv_valid = 1'b0;
    repeat (2) cyc();
    chk("en_count", KW'(q.size()), KW'(24));
    verify(0, 0);
    drv_en = 1'b1;
    cyc();
    chk("en_busy0", {71'd0, busy}, 72'd0);
    cyc();
    chk("en_busy1", {71'd0, busy}, 72'd1);

    // Asynchronous reset while a window is held
    do_reset();
    drv_valid = 1'b1;
    run_until(27);
    drv_valid = 1'b0; ordy_mode = 2;
    cyc();
    chk("ar_vld_pre", {71'd0, out_valid}, 72'd1);
    rst = 1'b0;
    #1;
    chk("ar_vld", {71'd0, out_valid}, 72'd0);
    chk("ar_busy", {71'd0, busy}, 72'd0);
    chk("ar_fcnt", {56'd0, frame_count}, 72'd0);
    @(negedge clk);
    rst = 1'b1;
    seq = 0; q.delete(); prev_stall = 1'b0; ordy_mode = 0;
    drv_valid = 1'b1;
    run_until(48);
    drain();
    chk("ar_count", KW'(q.size()), KW'(24));
    verify(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
